// File: rtl/spi_msg_arb_pkg.sv
// Shared types and constants for the SPI message arbiter: FSM states, the
// buffered word record and helpers for message length and round-robin wrap.
package spi_msg_arb_pkg;

  localparam int         LEN_W      = 9;
  localparam int         DATA_W     = 16;
  localparam logic [3:0] TAG_NIBBLE = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_READ,
    ST_DRAIN,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } word_t;

  // A head-message length of zero encodes a full 256-word message.
  function automatic logic [LEN_W-1:0] msg_words(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/spi_msg_arbiter_if.sv
// Downstream word stream of the SPI message arbiter (valid/ready handshake).
interface spi_msg_arbiter_if #(
  parameter int CH_W = 2
);
  import spi_msg_arb_pkg::*;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sop;
  logic              out_eop;
  logic [CH_W-1:0]   out_chan;

  modport master (
    output out_data, out_valid, out_sop, out_eop, out_chan,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_sop, out_eop, out_chan,
    output out_ready
  );

endinterface

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter_n
  import spi_msg_arb_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  input  logic            en,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] idx
);

  int c;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant = '0;
    idx   = '0;
    c     = 0;
    if (en) begin
      // Scan farthest-first so the nearest requester is the last (winning) assignment.
      for (int i = N_CH - 1; i >= 0; i--) begin
        c = wrap_idx(int'(ptr), i, N_CH);
        if (req[c]) begin
          grant    = '0;
          grant[c] = 1'b1;
          idx      = CH_W'(c);
        end
      end
    end
  end

endmodule

// File: rtl/spi_msg_arbiter.sv
// Round-robin controller draining one whole message per grant from N_CH SPI FIFOs
// into one 16-bit stream. Define SPI_MSG_ARB_CHAN_TAG_EN to prefix a channel tag word.
module spi_msg_arbiter
  import spi_msg_arb_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CH_W       = 2,
  parameter int GAP_CYCLES = 3
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        got_full_msg,
  input  logic [8*N_CH-1:0]      msg_len,
  input  logic [DATA_W*N_CH-1:0] fifo_q,
  output logic [N_CH-1:0]        rd_req,
  spi_msg_arbiter_if.master      stream,
  output logic                   busy,
  output logic [15:0]            msg_cnt
);

`ifdef SPI_MSG_ARB_CHAN_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t           state, state_nxt;
  logic [CH_W-1:0]  chan, rr_ptr, arb_idx;
  logic [N_CH-1:0]  arb_grant;
  logic             arb_en, arb_any;
  logic [LEN_W-1:0] len, issued, rcvd;
  logic             in_flight;
  logic [GAP_W-1:0] gap_cnt;
  word_t            buf0, buf1, push_word;
  logic [1:0]       cnt;
  logic [2:0]       occ;
  logic             push, pop, req_ok, drain_done;

  assign arb_en  = (state == ST_IDLE);
  assign arb_any = |arb_grant;

  rr_arbiter_n #(.N_CH(N_CH), .CH_W(CH_W)) u_rr (
    .req   (got_full_msg),
    .ptr   (rr_ptr),
    .en    (arb_en),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign stream.out_valid = (cnt != 2'd0);
  assign stream.out_data  = buf0.data;
  assign stream.out_sop   = stream.out_valid & buf0.sop;
  assign stream.out_eop   = stream.out_valid & buf0.eop;
  assign stream.out_chan  = chan;
  assign busy             = (state != ST_IDLE);

  assign pop  = stream.out_valid & stream.out_ready;
  assign push = in_flight | (TAG_EN && state == ST_GRANT);

  // Occupancy after this cycle's pop; a new request is allowed only if its word will fit.
  assign occ        = 3'(cnt) + 3'(in_flight) - 3'(pop);
  assign req_ok     = (issued < len) && (cnt != 2'd2) && (occ < 3'd2);
  assign drain_done = !in_flight && ((cnt == 2'd0) || (cnt == 2'd1 && pop));

  always_comb begin
    push_word = '{data: fifo_q[chan*DATA_W +: DATA_W],
                  sop:  !TAG_EN && (rcvd == '0),
                  eop:  rcvd == len - 1'b1};
    if (!in_flight) begin
      push_word = '{data: {TAG_NIBBLE, 4'(chan), len[7:0]}, sop: 1'b1, eop: 1'b0};
    end
  end

  always_comb begin
    state_nxt = state;
    rd_req    = '0;
    case (state)
      ST_IDLE:  if (arb_any) state_nxt = ST_GRANT;
      ST_GRANT: state_nxt = ST_READ;
      ST_READ: begin
        if (req_ok) begin
          rd_req[chan] = 1'b1;
          if (issued == len - 1'b1) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: if (drain_done) state_nxt = ST_GAP;
      ST_GAP:   if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      chan      <= '0;
      rr_ptr    <= '0;
      len       <= '0;
      issued    <= '0;
      rcvd      <= '0;
      in_flight <= 1'b0;
      gap_cnt   <= '0;
      cnt       <= '0;
      buf0      <= '0;
      msg_cnt   <= '0;
    end else begin
      in_flight <= |rd_req;
      cnt       <= cnt + 2'(push) - 2'(pop);
      gap_cnt   <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
      if (state == ST_IDLE && arb_any) begin
        chan   <= arb_idx;
        len    <= msg_words(msg_len[arb_idx*8 +: 8]);
        issued <= '0;
        rcvd   <= '0;
      end
      if (|rd_req) issued <= issued + 1'b1;
      if (in_flight) rcvd <= rcvd + 1'b1;
      if (state == ST_DRAIN && drain_done) begin
        msg_cnt <= msg_cnt + 1'b1;
        rr_ptr  <= (chan == CH_W'(N_CH - 1)) ? '0 : chan + 1'b1;
      end
      if (pop) buf0 <= buf1;
      if (push && (cnt - 2'(pop)) == 2'd0) buf0 <= push_word;
    end
  end

  // NOTE: the second skid slot is only read after being written, so it carries no reset.
  always_ff @(posedge sys_clk) begin
    if (push && (cnt - 2'(pop)) == 2'd1) buf1 <= push_word;
  end

endmodule
